// File: rtl/rx_hamming_pkg.sv
// Hamming(7,4) types and helpers shared by the RX corrector and the TX encoder.
// Bit layout: data e6,e5,e4,e2; parity e3,e1,e0.
package rx_hamming_pkg;

  typedef logic [6:0] code_t;
  typedef logic [3:0] nibble_t;
  typedef logic [2:0] synd_t;

  localparam synd_t SYND_CLEAN = 3'd0;

  // A non-zero syndrome value s points at bit e[s-1].
  function automatic synd_t syndrome(input code_t c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic nibble_t extract(input code_t c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/module_rx_bitfix.sv
// Combinational single-bit corrector: flips e[synd-1] when the syndrome is non-zero.
// Zero latency; no flow control of its own.
module module_rx_bitfix
  import rx_hamming_pkg::*;
(
  input  code_t code,
  input  synd_t synd,
  output code_t fixed
);

  always_comb begin
    fixed = code;
    if (synd != SYND_CLEAN) begin
      fixed[synd - 3'd1] = ~code[synd - 3'd1];
    end
  end

endmodule

// File: rtl/module_rx_corrector.sv
// Hamming(7,4) RX corrector: 2-stage valid/ready pipeline plus a saturating error counter.
// Latency 2 clk, 1 word/clk; a stalled output holds both stages and drops in_ready.
module module_rx_corrector
  import rx_hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [3:0]       out_syndrome,
  output logic             out_err,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic    s1_valid;
  code_t   s1_code;
  synd_t   s1_synd;

  logic    s2_valid;
  nibble_t s2_data;
  synd_t   s2_synd;
  logic    s2_err;

  logic    adv1;
  logic    adv2;
  code_t   s1_fixed;

  // No skid buffer: in_ready follows out_ready combinationally through both stages.
  assign adv2     = ~s2_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_synd  <= SYND_CLEAN;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_synd <= syndrome(in_code);
      end
    end
  end

  module_rx_bitfix u_bitfix (
    .code  (s1_code),
    .synd  (s1_synd),
    .fixed (s1_fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_synd  <= SYND_CLEAN;
      s2_err   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= extract(s1_fixed);
        s2_synd <= s1_synd;
        s2_err  <= (s1_synd != SYND_CLEAN);
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_data     = s2_data;
  assign out_syndrome = {1'b0, s2_synd};
  assign out_err      = s2_err;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && s2_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
